conv_maxpool: RTL and testbench
===============================

Name: conv_maxpool

Overview:
- Downstream of the conv stage. Consumes the per-pixel, all-filter output stream of conv (o_feature_valid / o_features) in raster order.
- Applies optional ReLU, then 2x2 stride-2 max pooling per filter channel.
- Emits a pooled raster stream (28x28 -> 14x14 at defaults) toward feature_map_stream.
- No backpressure: output rate is at most one pooled pixel per four accepted inputs.

Parameters:
- NUM_FILTERS, 6: channels per pixel; all pooled in parallel.
- DATA_WIDTH, 16: signed width of each channel value.
- IN_COLS, 28: input columns per row; must be even (elaboration error otherwise).
- IN_ROWS, 28: input rows per frame; must be even (elaboration error otherwise).
- APPLY_RELU, 1: when 1, negative inputs are clamped to 0 before pooling; when 0, values pass through unchanged.

Ports:
- i_clk, input, 1: clock. Single domain; all state is rising-edge.
- i_rst, input, 1: asynchronous, active-high reset.
- i_feature_valid, input, 1: i_features holds one input pixel this cycle.
- i_features, input, NUM_FILTERS x DATA_WIDTH signed: channel values of the current pixel.
- o_feature_valid, output, 1: o_features holds one pooled pixel this cycle.
- o_features, output, NUM_FILTERS x DATA_WIDTH signed: pooled channel values.
- o_frame_done, output, 1: one-cycle pulse, coincident with the last pooled pixel of a frame.

Behaviour:
- Reset (async assert, any time, including mid-frame):
  - col_cnt=0, row_cnt=0, all pair registers 0.
  - o_feature_valid=0, o_features all 0, o_frame_done=0.
  - Line buffer contents are don't-care and are not cleared.
  - The first pixel after reset is treated as (row 0, col 0).
- Accept / stall:
  - A pixel is accepted only on a cycle with i_feature_valid=1.
  - Invalid cycles freeze all state.
  - Gaps of any length between valid pixels are legal.
- Counters:
  - col_cnt runs 0..IN_COLS-1.
  - At IN_COLS-1 it wraps to 0 and row_cnt increments.
  - At row IN_ROWS-1, col IN_COLS-1 both counters wrap to 0 (next frame).
- Per channel, with r = ReLU(x) or x depending on APPLY_RELU:
  - Even col: pair_reg <= r.
  - Odd col: hmax = max(pair_reg, r), signed compare, combinational.
  - Even row, odd col: line_buf[col_cnt>>1] <= hmax. Line buffer depth is IN_COLS/2 entries of NUM_FILTERS x DATA_WIDTH.
  - Odd row, odd col: o_features <= max(line_buf[col_cnt>>1], hmax), and o_feature_valid <= 1 on the next clock edge.
  - Latency is 1 cycle from the accepting edge.
- o_feature_valid is a single-cycle pulse. o_features holds its last value when valid is low.
- o_frame_done=1 together with o_feature_valid for the pooled pixel generated from input (IN_ROWS-1, IN_COLS-1).
- The line buffer read for an odd row always follows the write in the preceding even row. No read-before-write hazard exists within a frame.
- Ties: either operand may be chosen; values are equal.
- Output count per frame: (IN_ROWS/2)*(IN_COLS/2) pulses, in pooled raster order.
- No arithmetic widening. max() and ReLU are exact in DATA_WIDTH.

Test Plan:
- Ramp frame: channel k of pixel (r,c) = r*28+c+k, APPLY_RELU=1, continuous valid.
  - Expect 196 pulses.
  - Pooled (i,j) channel k = (2i+1)*28+2j+1+k.
  - First pulse 1 cycle after input (1,1) is accepted; o_frame_done only on pulse 196.
- All-negative frame (every value -5):
  - APPLY_RELU=1: all outputs 0.
  - APPLY_RELU=0: all outputs -5.
- Single hot pixel: value 0x7FFF at (10,13) on channel 2, all else -32768, APPLY_RELU=0.
  - Output (5,6) channel 2 = 0x7FFF.
  - All other outputs -32768.
- Gapped input: valid toggles 1,0,0,1… with random gaps on the ramp frame.
  - Identical output values and order to scenario 1; no pulse on any stall cycle.
- Reset mid-frame: assert i_rst at input (7,9) for 2 cycles.
  - Outputs go 0 immediately (async).
  - Then stream a full ramp frame; expect exactly 196 pulses matching scenario 1.
- Back-to-back frames: two ramp frames with no gap.
  - 392 pulses; o_frame_done on pulses 196 and 392.
  - Frame-2 values are not corrupted by frame-1 line buffer contents.

Source files
------------

// File: rtl/conv_maxpool_if.sv
// ---------------------------------------------------------------------------
// conv_maxpool_if
// Stream bundle between the conv stage, the 2x2 max-pool block and the
// feature_map_stream consumer.
//
// Signals:
//   i_feature_valid  one input pixel is present on i_features this cycle
//   i_features       NUM_FILTERS signed channel values of the input pixel
//   o_feature_valid  one pooled pixel is present on o_features this cycle
//   o_features       NUM_FILTERS signed pooled channel values
//   o_frame_done     pulse with the last pooled pixel of a frame
//
// Modports:
//   master  the side that feeds pixels in and observes pooled results
//   slave   the pooling block itself
// ---------------------------------------------------------------------------
interface conv_maxpool_if #(
   parameter int NUM_FILTERS = 6,
   parameter int DATA_WIDTH  = 16
);

   logic                                   i_feature_valid;
   logic [NUM_FILTERS-1:0][DATA_WIDTH-1:0] i_features;
   logic                                   o_feature_valid;
   logic [NUM_FILTERS-1:0][DATA_WIDTH-1:0] o_features;
   logic                                   o_frame_done;

   modport master (
      output i_feature_valid,
      output i_features,
      input  o_feature_valid,
      input  o_features,
      input  o_frame_done
   );

   modport slave (
      input  i_feature_valid,
      input  i_features,
      output o_feature_valid,
      output o_features,
      output o_frame_done
   );

endinterface

// File: rtl/conv_maxpool.sv
// ---------------------------------------------------------------------------
// conv_maxpool
// Optional ReLU followed by 2x2 stride-2 max pooling of a raster-ordered,
// all-channels-per-pixel feature stream. Every channel is pooled in parallel.
// A pooled pixel is produced on the cycle after the bottom-right pixel of its
// 2x2 window is accepted.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst    asynchronous active-high reset
//   stream   conv_maxpool_if.slave
//              i_feature_valid / i_features          input pixel stream
//              o_feature_valid / o_features          pooled pixel stream
//              o_frame_done                          last pooled pixel of frame
// ---------------------------------------------------------------------------
module conv_maxpool #(
   parameter int NUM_FILTERS = 6,
   parameter int DATA_WIDTH  = 16,
   parameter int IN_COLS     = 28,
   parameter int IN_ROWS     = 28,
   parameter bit APPLY_RELU  = 1'b1
) (
   input  logic           i_clk,
   input  logic           i_rst,
   conv_maxpool_if.slave  stream
);

   // Column counter keeps at least two bits so the half-column index used
   // for the line buffer is never an empty slice.
   localparam int COL_W = (IN_COLS > 2) ? $clog2(IN_COLS) : 2;
   localparam int ROW_W = (IN_ROWS > 2) ? $clog2(IN_ROWS) : 1;
   localparam int HALF  = IN_COLS / 2;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_ROWS - 1);

   typedef logic [NUM_FILTERS-1:0][DATA_WIDTH-1:0] pix_t;

   // Odd frame dimensions would leave an unpaired column or row, which the
   // 2x2 window logic cannot represent, so refuse to elaborate.
   if ((IN_COLS % 2) != 0 || IN_COLS < 2) begin : gBadCols
      $error("conv_maxpool: IN_COLS must be a positive even number");
   end
   if ((IN_ROWS % 2) != 0 || IN_ROWS < 2) begin : gBadRows
      $error("conv_maxpool: IN_ROWS must be a positive even number");
   end

   logic [COL_W-1:0] colCnt_q, colCnt_d;
   logic [ROW_W-1:0] rowCnt_q, rowCnt_d;
   pix_t             pair_q;
   pix_t             outFeatures_q;
   logic             outValid_q;
   logic             frameDone_q;

   pix_t             lineBuf [HALF];

   logic             accept;
   logic             colOdd;
   logic             rowOdd;
   logic             colLast;
   logic             rowLast;
   logic [COL_W-2:0] halfIdx;
   pix_t             reluPix;
   pix_t             hMax;
   pix_t             lineRd;
   pix_t             pooled;

   assign accept  = stream.i_feature_valid;
   assign colOdd  = colCnt_q[0];
   assign rowOdd  = rowCnt_q[0];
   assign colLast = (colCnt_q == COL_LAST);
   assign rowLast = (rowCnt_q == ROW_LAST);
   assign halfIdx = colCnt_q[COL_W-1:1];
   assign lineRd  = lineBuf[halfIdx];

   // Per-channel datapath: clamp negatives when ReLU is enabled, take the
   // horizontal max against the held even-column value, then the vertical
   // max against the value the even row left in the line buffer. All
   // compares are signed and stay in DATA_WIDTH, so no widening is needed.
   always_comb begin
      reluPix = '0;
      hMax    = '0;
      pooled  = '0;
      for (int k = 0; k < NUM_FILTERS; k++) begin
         if (APPLY_RELU && stream.i_features[k][DATA_WIDTH-1]) begin
            reluPix[k] = '0;
         end else begin
            reluPix[k] = stream.i_features[k];
         end
         if ($signed(pair_q[k]) > $signed(reluPix[k])) begin
            hMax[k] = pair_q[k];
         end else begin
            hMax[k] = reluPix[k];
         end
         if ($signed(lineRd[k]) > $signed(hMax[k])) begin
            pooled[k] = lineRd[k];
         end else begin
            pooled[k] = hMax[k];
         end
      end
   end

   // Raster position tracking: columns wrap into the next row, and the last
   // pixel of the last row wraps both counters back to the frame origin.
   always_comb begin
      colCnt_d = colCnt_q;
      rowCnt_d = rowCnt_q;
      if (accept) begin
         if (colLast) begin
            colCnt_d = '0;
            if (rowLast) begin
               rowCnt_d = '0;
            end else begin
               rowCnt_d = rowCnt_q + 1'b1;
            end
         end else begin
            colCnt_d = colCnt_q + 1'b1;
         end
      end
   end

   // Control and output registers. Valid and frame-done default low every
   // cycle so each pooled pixel is a single-cycle pulse, while the feature
   // register holds its last value between pulses. Idle cycles change
   // nothing but those two pulse flags.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         colCnt_q      <= '0;
         rowCnt_q      <= '0;
         pair_q        <= '0;
         outFeatures_q <= '0;
         outValid_q    <= 1'b0;
         frameDone_q   <= 1'b0;
      end else begin
         outValid_q  <= 1'b0;
         frameDone_q <= 1'b0;
         colCnt_q    <= colCnt_d;
         rowCnt_q    <= rowCnt_d;
         if (accept) begin
            if (!colOdd) begin
               pair_q <= reluPix;
            end else if (rowOdd) begin
               outFeatures_q <= pooled;
               outValid_q    <= 1'b1;
               frameDone_q   <= colLast && rowLast;
            end
         end
      end
   end

   // Line buffer holding the horizontal maxima of the current even row.
   // It needs no reset: every entry an odd row reads was written earlier in
   // the same frame by the even row above it.
   always_ff @(posedge i_clk) begin
      if (accept && colOdd && !rowOdd) begin
         lineBuf[halfIdx] <= hMax;
      end
   end

   assign stream.o_feature_valid = outValid_q;
   assign stream.o_features      = outFeatures_q;
   assign stream.o_frame_done    = frameDone_q;

endmodule

// File: tb/tb_conv_maxpool.sv
// ---------------------------------------------------------------------------
// tb_conv_maxpool
// Drives two conv_maxpool instances (ReLU on and ReLU off) with the same
// pixel stream and compares every pooled pulse against a frame-level model
// that takes the max of each 2x2 window directly from a stored frame.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conv_maxpool;

   localparam int NF     = 6;
   localparam int DW     = 16;
   localparam int COLS   = 28;
   localparam int ROWS   = 28;
   localparam int FW     = NF * DW;
   localparam int FULL   = ROWS * COLS;

   logic                  iClk = 1'b0;
   logic                  iRst;
   logic                  feedValid;
   logic [NF-1:0][DW-1:0] feedFeatures;

   int vectorCount = 0;
   int missCount   = 0;
   int cycleCnt    = 0;
   int pulsesRelu  = 0;
   int pulsesRaw   = 0;

   logic signed [DW-1:0] pix [ROWS][COLS][NF];
   logic [FW:0]          expRelu [$];
   logic [FW:0]          expRaw  [$];
   int                   accRelu [$];
   int                   accRaw  [$];

   conv_maxpool_if #(.NUM_FILTERS(NF), .DATA_WIDTH(DW)) reluIf ();
   conv_maxpool_if #(.NUM_FILTERS(NF), .DATA_WIDTH(DW)) rawIf ();

   assign reluIf.i_feature_valid = feedValid;
   assign reluIf.i_features      = feedFeatures;
   assign rawIf.i_feature_valid  = feedValid;
   assign rawIf.i_features       = feedFeatures;

   conv_maxpool #(
      .NUM_FILTERS(NF), .DATA_WIDTH(DW), .IN_COLS(COLS), .IN_ROWS(ROWS),
      .APPLY_RELU(1'b1)
   ) dutRelu (
      .i_clk  (iClk),
      .i_rst  (iRst),
      .stream (reluIf)
   );

   conv_maxpool #(
      .NUM_FILTERS(NF), .DATA_WIDTH(DW), .IN_COLS(COLS), .IN_ROWS(ROWS),
      .APPLY_RELU(1'b0)
   ) dutRaw (
      .i_clk  (iClk),
      .i_rst  (iRst),
      .stream (rawIf)
   );

   // Free-running clock and an edge counter used for latency checks.
   always #5 iClk = ~iClk;

   always @(posedge iClk) cycleCnt <= cycleCnt + 1;

   // Absolute time limit so a stuck run still ends with a report.
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic int reluOf(input int x, input bit relu);
      return (relu && x < 0) ? 0 : x;
   endfunction

   // Max over the 2x2 input window feeding pooled pixel (i,j).
   function automatic logic [FW-1:0] pooledExpect(input int i, input int j, input bit relu);
      logic [NF-1:0][DW-1:0] res;
      int best;
      int v;
      res = '0;
      for (int k = 0; k < NF; k++) begin
         best = reluOf(int'(pix[2*i][2*j][k]), relu);
         for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
               v = reluOf(int'(pix[2*i+dr][2*j+dc][k]), relu);
               if (v > best) best = v;
            end
         end
         res[k] = DW'(best);
      end
      return res;
   endfunction

   // Fill the frame and queue the pooled pixels whose window completes
   // within the first 'limit' pixels of the raster.
   task automatic prepareFrame(input int scenario, input int limit, output int pushed);
      int last;
      bit done;
      pushed = 0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            for (int k = 0; k < NF; k++) begin
               case (scenario)
                  0: pix[r][c][k] = DW'(r * COLS + c + k);
                  1: pix[r][c][k] = -16'sd5;
                  2: pix[r][c][k] = (r == 10 && c == 13 && k == 2) ? 16'sh7FFF : 16'sh8000;
                  default: pix[r][c][k] = DW'($urandom);
               endcase
            end
         end
      end
      for (int i = 0; i < ROWS / 2; i++) begin
         for (int j = 0; j < COLS / 2; j++) begin
            last = (2 * i + 1) * COLS + 2 * j + 1;
            if (last < limit) begin
               done = (last == FULL - 1);
               expRelu.push_back({done, pooledExpect(i, j, 1'b1)});
               expRaw.push_back({done, pooledExpect(i, j, 1'b0)});
               pushed++;
            end
         end
      end
   endtask

   // Stream 'limit' raster pixels of the stored frame, nFrames times, with
   // up to gapMax idle cycles before each pixel.
   task automatic applyStimulus(input int limit, input int gapMax, input int nFrames);
      int r;
      int c;
      int gap;
      for (int f = 0; f < nFrames; f++) begin
         for (int n = 0; n < limit; n++) begin
            r = n / COLS;
            c = n % COLS;
            gap = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
            repeat (gap) begin
               @(negedge iClk);
               feedValid = 1'b0;
            end
            @(negedge iClk);
            feedValid = 1'b1;
            for (int k = 0; k < NF; k++) feedFeatures[k] = pix[r][c][k];
            if ((r % 2) == 1 && (c % 2) == 1) begin
               accRelu.push_back(cycleCnt + 1);
               accRaw.push_back(cycleCnt + 1);
            end
         end
      end
      @(negedge iClk);
      feedValid = 1'b0;
   endtask

   task automatic monitorDut(input int id, input logic v, input logic [FW-1:0] f,
                             input logic fd);
      logic [FW:0] e;
      int a;
      bit haveExp;
      string nm;
      nm = (id == 0) ? "relu" : "raw";
      if (v) begin
         haveExp = (id == 0) ? (expRelu.size() > 0 && accRelu.size() > 0)
                             : (expRaw.size() > 0 && accRaw.size() > 0);
         if (!haveExp) begin
            checkOutput({nm, "_spurious_pulse"}, 128'(v), 128'(0));
         end else begin
            if (id == 0) begin
               e = expRelu.pop_front();
               a = accRelu.pop_front();
               pulsesRelu++;
            end else begin
               e = expRaw.pop_front();
               a = accRaw.pop_front();
               pulsesRaw++;
            end
            checkOutput({nm, "_features"}, 128'(f), 128'(e[FW-1:0]));
            checkOutput({nm, "_frame_done"}, 128'(fd), 128'(e[FW]));
            checkOutput({nm, "_latency_edge"}, 128'(cycleCnt), 128'(a));
         end
      end else if (fd) begin
         checkOutput({nm, "_done_without_valid"}, 128'(fd), 128'(0));
      end
   endtask

   // Outputs are sampled on the falling edge, away from the register update.
   always @(negedge iClk) begin
      if (!iRst) begin
         monitorDut(0, reluIf.o_feature_valid, reluIf.o_features, reluIf.o_frame_done);
         monitorDut(1, rawIf.o_feature_valid, rawIf.o_features, rawIf.o_frame_done);
      end
   end

   task automatic waitDrain();
      int budget;
      budget = 0;
      while ((expRelu.size() > 0 || expRaw.size() > 0) && budget < 20) begin
         @(negedge iClk);
         budget++;
      end
      repeat (4) @(negedge iClk);
      checkOutput("relu_undelivered", 128'(expRelu.size()), 128'(0));
      checkOutput("raw_undelivered", 128'(expRaw.size()), 128'(0));
   endtask

   task automatic runFrame(input int scenario, input int limit, input int gapMax);
      int pushed;
      int startRelu;
      int startRaw;
      startRelu = pulsesRelu;
      startRaw  = pulsesRaw;
      prepareFrame(scenario, limit, pushed);
      applyStimulus(limit, gapMax, 1);
      waitDrain();
      checkOutput("relu_pulse_count", 128'(pulsesRelu - startRelu), 128'(pushed));
      checkOutput("raw_pulse_count", 128'(pulsesRaw - startRaw), 128'(pushed));
   endtask

   task automatic checkQuiet(input string tag);
      checkOutput({tag, "_relu_valid"}, 128'(reluIf.o_feature_valid), 128'(0));
      checkOutput({tag, "_relu_features"}, 128'(reluIf.o_features), 128'(0));
      checkOutput({tag, "_relu_done"}, 128'(reluIf.o_frame_done), 128'(0));
      checkOutput({tag, "_raw_valid"}, 128'(rawIf.o_feature_valid), 128'(0));
      checkOutput({tag, "_raw_features"}, 128'(rawIf.o_features), 128'(0));
      checkOutput({tag, "_raw_done"}, 128'(rawIf.o_frame_done), 128'(0));
   endtask

   initial begin
      int pushed;
      int startRelu;
      iRst         = 1'b1;
      feedValid    = 1'b0;
      feedFeatures = '0;
      repeat (3) @(negedge iClk);
      checkQuiet("reset");
      iRst = 1'b0;

      $display("[TB] ramp frame");
      runFrame(0, FULL, 0);

      $display("[TB] all-negative frame");
      runFrame(1, FULL, 0);

      $display("[TB] single hot pixel frame");
      runFrame(2, FULL, 0);

      $display("[TB] gapped ramp frame");
      runFrame(0, FULL, 3);

      $display("[TB] reset in the middle of a frame");
      runFrame(0, 7 * COLS + 9, 0);
      @(negedge iClk);
      #1 iRst = 1'b1;
      #1 checkQuiet("async_reset");
      @(posedge iClk);
      @(posedge iClk);
      @(negedge iClk);
      iRst = 1'b0;
      runFrame(0, FULL, 0);

      $display("[TB] back-to-back ramp frames");
      startRelu = pulsesRelu;
      prepareFrame(0, FULL, pushed);
      prepareFrame(0, FULL, pushed);
      applyStimulus(FULL, 0, 2);
      waitDrain();
      checkOutput("b2b_pulse_count", 128'(pulsesRelu - startRelu), 128'(2 * pushed));

      $display("[TB] random-valued gapped frame");
      runFrame(3, FULL, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
